// File: rtl/hilbert_fir_mac_pkg.sv
// Shared parameters, FSM state type and output saturation for the Hilbert FIR MAC engine.
// Coefficients, samples and output are all Q8.24.
package hilbert_pkg;

  localparam int DW   = 32;
  localparam int FRAC = 24;
  localparam int TAPS = 32;
  localparam int AW   = 5;
  localparam int ACCW = 72;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic [DW-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DW-1:0] SAT_MIN = 32'h8000_0000;

  // Floor shift back to Q8.24, then clamp when the dropped upper bits are not pure sign extension.
  function automatic logic [DW-1:0] sat_shift(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] sh;
    logic [DW-1:0]          res;
    sh = acc >>> FRAC;
    if ((&sh[ACCW-1:DW-1]) || !(|sh[ACCW-1:DW-1])) begin
      res = sh[DW-1:0];
    end else if (sh[ACCW-1]) begin
      res = SAT_MIN;
    end else begin
      res = SAT_MAX;
    end
    return res;
  endfunction

endpackage

// File: rtl/hilbert_fir_mac_delay_line.sv
// 32-deep sample history: single write port, combinational read by index, synchronous clear.
module hilbert_delay_line
  import hilbert_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [TAPS];

  // History storage; clear takes priority over a write.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < TAPS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hilbert_fir_mac.sv
// Sequential 32-tap Hilbert FIR: one sample in, 32 MAC cycles against the coefficient ROM,
// one saturated Q8.24 sample out on a valid/ready handshake.
module hilbert_fir_mac
  import hilbert_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic          flush_i,
  output logic [AW-1:0] rom_addr_o,
  input  logic [DW-1:0] rom_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          busy_o
);

  state_e                 state_q;
  logic [AW-1:0]          wp_q;
  logic [AW-1:0]          cur_q;
  logic [AW-1:0]          k_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_d;
  logic [DW-1:0]          out_data_q;
  logic                   out_valid_q;
  logic                   in_ready_q;
  logic                   busy_q;

  logic [DW-1:0]          tap_s;
  logic signed [2*DW-1:0] prod_s;
  logic                   line_we_s;
  logic                   line_clr_s;
  logic [AW-1:0]          raddr_s;

  assign line_clr_s = (state_q == IDLE) && flush_i;
  assign line_we_s  = (state_q == IDLE) && in_valid_i && !flush_i;
  assign raddr_s    = cur_q - k_q;

  hilbert_delay_line u_line (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .clr_i   (line_clr_s),
    .we_i    (line_we_s),
    .waddr_i (wp_q),
    .wdata_i (in_data_i),
    .raddr_i (raddr_s),
    .rdata_o (tap_s)
  );

  // Operands are sign-extended to the full product width so the low half is the exact signed product.
  assign prod_s = $signed({{DW{rom_data_i[DW-1]}}, rom_data_i}) * $signed({{DW{tap_s[DW-1]}}, tap_s});

  // Next accumulator value for the current tap.
  always_comb begin
    acc_d = acc_q;
    if (state_q == MAC) begin
      acc_d = acc_q + $signed({{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s});
    end else begin
      acc_d = acc_q;
    end
  end

  // Control FSM with registered handshake, address and result outputs.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      cur_q       <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_i) begin
            wp_q <= '0;
          end else if (in_valid_i) begin
            cur_q      <= wp_q;
            wp_q       <= wp_q + AW'(1);
            acc_q      <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          // k stays at 31 after the last tap so the ROM address holds through OUT.
          if (k_q == AW'(TAPS - 1)) begin
            out_data_q  <= sat_shift(acc_d);
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= OUT;
          end else begin
            k_q <= k_q + AW'(1);
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            k_q         <= '0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          k_q         <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign rom_addr_o  = k_q;
  assign busy_o      = busy_q;

endmodule
